// File: rtl/ir_rx_sequencer.sv
// IR receive sequencer: arms the receiver, waits for a frame with timeout and retry,
// validates NEC address/command inverses and buffers the decoded code for a consumer.
module ir_rx_sequencer #(
   parameter int unsigned TIMEOUT_CYCLES = 2000000,
   parameter int unsigned MAX_RETRY      = 3,
   parameter bit          CHECK_INV      = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   output logic        rx_read,
   input  logic        rx_done,
   input  logic        rx_error,
   input  logic [31:0] rx_data,
   output logic        code_valid,
   input  logic        code_ready,
   output logic [7:0]  code_addr,
   output logic [7:0]  code_cmd,
   output logic        overflow,
   output logic        give_up,
   output logic [7:0]  err_count,
   output logic        busy
);

   localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam int RW = (MAX_RETRY > 1) ? $clog2(MAX_RETRY + 1) : 1;
   localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [RW:0]   RETRY_MAX  = (RW + 1)'(MAX_RETRY);

   typedef enum logic [2:0] {IDLE, ARM, WAIT, CHECK, RETRY} state_t;

   state_t          state;
   logic [TW-1:0]   timer;
   logic [RW-1:0]   retry_cnt;
   logic [31:0]     frame;
   logic            check_ok;
   logic            load_req;
   logic [RW:0]     retry_next;

   assign check_ok   = !CHECK_INV || ((frame[15:8] == ~frame[7:0]) &&
                                      (frame[31:24] == ~frame[23:16]));
   assign load_req   = (state == CHECK) && check_ok;
   assign retry_next = {1'b0, retry_cnt} + 1'b1;
   assign busy       = (state != IDLE);

   // NOTE: all state here uses <= so every branch sees the pre-edge values,
   // independent of statement order inside the block.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         timer      <= '0;
         retry_cnt  <= '0;
         frame      <= '0;
         rx_read    <= 1'b0;
         give_up    <= 1'b0;
         code_valid <= 1'b0;
         code_addr  <= '0;
         code_cmd   <= '0;
         overflow   <= 1'b0;
         err_count  <= '0;
      end else begin
         rx_read <= 1'b0;
         give_up <= 1'b0;

         // A consumer draining this cycle frees the slot for a same-cycle load.
         if (load_req && (!code_valid || code_ready)) begin
            code_valid <= 1'b1;
            code_addr  <= frame[7:0];
            code_cmd   <= frame[23:16];
         end else begin
            if (code_valid && code_ready) code_valid <= 1'b0;
            if (load_req)                 overflow   <= 1'b1;
         end

         case (state)
            IDLE: begin
               if (enable) begin
                  state   <= ARM;
                  rx_read <= 1'b1;
               end
            end
            ARM: begin
               timer <= '0;
               state <= WAIT;
            end
            WAIT: begin
               timer <= timer + 1'b1;
               if (rx_done) begin
                  frame <= rx_data;
                  state <= CHECK;
               end else if (rx_error || (timer == TIMER_LAST)) begin
                  state <= RETRY;
               end
            end
            CHECK: begin
               if (check_ok) begin
                  retry_cnt <= '0;
                  if (enable) begin
                     state   <= ARM;
                     rx_read <= 1'b1;
                  end else begin
                     state <= IDLE;
                  end
               end else begin
                  state <= RETRY;
               end
            end
            RETRY: begin
               if (err_count != 8'hFF) err_count <= err_count + 8'd1;
               if ((retry_next < RETRY_MAX) && enable) begin
                  retry_cnt <= retry_next[RW-1:0];
                  state     <= ARM;
                  rx_read   <= 1'b1;
               end else begin
                  retry_cnt <= '0;
                  give_up   <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ir_rx_sequencer.sv
// Self-checking bench for ir_rx_sequencer: the bench plays the IR receiver and predicts
// each capture attempt's outcome, retries, error count and output buffer contents.
module tb_ir_rx_sequencer;

   localparam int TO = 16;
   localparam int MR = 3;

   logic        clk = 1'b0;
   logic        reset;
   logic        enable;
   logic        rx_read;
   logic        rx_done;
   logic        rx_error;
   logic [31:0] rx_data;
   logic        code_valid;
   logic        code_ready;
   logic [7:0]  code_addr;
   logic [7:0]  code_cmd;
   logic        overflow;
   logic        give_up;
   logic [7:0]  err_count;
   logic        busy;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model state
   bit       m_valid;
   logic [7:0] m_addr, m_cmd;
   bit       m_ovf;
   int       m_err;
   int       m_retry;
   int       ready_mode;   // 0 random, 1 always ready, 2 never ready, 3 ready only on load

   ir_rx_sequencer #(
      .TIMEOUT_CYCLES(TO),
      .MAX_RETRY(MR),
      .CHECK_INV(1'b1)
   ) dut (
      .clk(clk),
      .reset(reset),
      .enable(enable),
      .rx_read(rx_read),
      .rx_done(rx_done),
      .rx_error(rx_error),
      .rx_data(rx_data),
      .code_valid(code_valid),
      .code_ready(code_ready),
      .code_addr(code_addr),
      .code_cmd(code_cmd),
      .overflow(overflow),
      .give_up(give_up),
      .err_count(err_count),
      .busy(busy)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] nec(input logic [7:0] a, input logic [7:0] c);
      return {~c, c, ~a, a};
   endfunction

   // One clock: drive code_ready, advance the buffer model, then compare all outputs.
   task automatic tick(input bit load, input logic [7:0] a, input logic [7:0] c,
                       input bit exp_read, input bit exp_give, input bit exp_busy);
      bit rdy;
      case (ready_mode)
         0:       rdy = 1'($urandom % 2);
         1:       rdy = 1'b1;
         2:       rdy = 1'b0;
         default: rdy = load;
      endcase
      code_ready = rdy;
      if (load) begin
         if (!m_valid || rdy) begin
            m_valid = 1'b1;
            m_addr  = a;
            m_cmd   = c;
         end else begin
            m_ovf = 1'b1;
         end
      end else if (m_valid && rdy) begin
         m_valid = 1'b0;
      end
      @(posedge clk);
      #1;
      check("rx_read", rx_read, exp_read);
      check("give_up", give_up, exp_give);
      check("busy", busy, exp_busy);
      check("code_valid", code_valid, m_valid);
      check("overflow", overflow, m_ovf);
      check("err_count", err_count, m_err);
      if (m_valid) begin
         check("code_addr", code_addr, m_addr);
         check("code_cmd", code_cmd, m_cmd);
      end
   endtask

   // One capture attempt, entered in the ARM cycle. kind: 0 done, 1 error, 2 timeout, 3 done+error.
   task automatic attempt(input int kind, input int d, input logic [31:0] data,
                          input bit rnd_en, output bit gave_up);
      bit pass;
      bit last;
      gave_up = 1'b0;
      pass = (data[15:8] == ~data[7:0]) && (data[31:24] == ~data[23:16]);
      tick(1'b0, 8'h0, 8'h0, 1'b0, 1'b0, 1'b1);
      for (int w = 1; w <= TO; w++) begin
         if (rnd_en) enable = 1'($urandom % 2);
         rx_data = $urandom;
         last = (w == TO) || ((kind != 2) && (w == d));
         if ((kind != 2) && (w == d)) begin
            rx_done  = (kind == 0) || (kind == 3);
            rx_error = (kind == 1) || (kind == 3);
            if (rx_done) rx_data = data;
         end
         tick(1'b0, 8'h0, 8'h0, 1'b0, 1'b0, 1'b1);
         rx_done  = 1'b0;
         rx_error = 1'b0;
         rx_data  = $urandom;
         if (last) break;
      end
      enable = 1'b1;
      if (((kind == 0) || (kind == 3)) && pass) begin
         m_retry = 0;
         tick(1'b1, data[7:0], data[23:16], 1'b1, 1'b0, 1'b1);
      end else begin
         if ((kind == 0) || (kind == 3))
            tick(1'b0, 8'h0, 8'h0, 1'b0, 1'b0, 1'b1);
         m_err = (m_err >= 255) ? 255 : m_err + 1;
         m_retry++;
         if (m_retry >= MR) begin
            m_retry = 0;
            gave_up = 1'b1;
            tick(1'b0, 8'h0, 8'h0, 1'b0, 1'b1, 1'b0);
         end else begin
            tick(1'b0, 8'h0, 8'h0, 1'b1, 1'b0, 1'b1);
         end
      end
   endtask

   task automatic model_reset();
      m_valid = 1'b0;
      m_addr  = '0;
      m_cmd   = '0;
      m_ovf   = 1'b0;
      m_err   = 0;
      m_retry = 0;
   endtask

   initial begin
      bit g;
      int kind;
      logic [31:0] f;

      reset = 1'b0; enable = 1'b0; rx_done = 1'b0; rx_error = 1'b0;
      rx_data = '0; code_ready = 1'b0; ready_mode = 1;
      model_reset();
      #3;
      check("rst_rx_read", rx_read, 0);
      check("rst_code_valid", code_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_err_count", err_count, 0);
      check("rst_code_addr", {code_addr, code_cmd}, 0);
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1; enable = 1'b1;
      tick(1'b0, 8'h0, 8'h0, 1'b1, 1'b0, 1'b1);

      // Good frame, immediate re-arm, rx_read pulse is one cycle
      attempt(0, 1, 32'hBF40_FD02, 1'b0, g);
      check("good_addr", code_addr, 8'h02);
      check("good_cmd", code_cmd, 8'h40);

      // Three bad inverse frames exhaust the retries; idle while disabled
      for (int i = 0; i < MR; i++) attempt(0, 2, 32'h0040_FD02, 1'b0, g);
      check("give_up_after_3", g, 1);
      enable = 1'b0;
      repeat (3) tick(1'b0, 8'h0, 8'h0, 1'b0, 1'b0, 1'b0);
      enable = 1'b1;
      tick(1'b0, 8'h0, 8'h0, 1'b1, 1'b0, 1'b1);

      // Backpressure: hold first, drop second, load third on a same-cycle drain
      ready_mode = 2;
      attempt(0, 3, nec(8'h11, 8'h22), 1'b0, g);
      attempt(0, 1, nec(8'h33, 8'h44), 1'b0, g);
      ready_mode = 3;
      attempt(0, TO, nec(8'h55, 8'h66), 1'b0, g);
      ready_mode = 1;

      // Timeout, then simultaneous done/error with a good frame
      attempt(2, 0, 32'h0, 1'b0, g);
      attempt(3, 4, nec(8'hA5, 8'h3C), 1'b0, g);

      // Asynchronous reset in the middle of WAIT
      ready_mode = 2;
      tick(1'b0, 8'h0, 8'h0, 1'b0, 1'b0, 1'b1);
      tick(1'b0, 8'h0, 8'h0, 1'b0, 1'b0, 1'b1);
      #2 reset = 1'b0;
      #1;
      check("mid_rst_outputs", {rx_read, code_valid, overflow, give_up, busy}, 0);
      check("mid_rst_err", err_count, 0);
      check("mid_rst_code", {code_addr, code_cmd}, 0);
      model_reset();
      @(posedge clk);
      #1;
      reset = 1'b1; enable = 1'b1; ready_mode = 0;
      tick(1'b0, 8'h0, 8'h0, 1'b1, 1'b0, 1'b1);

      // Randomized attempts
      for (int n = 0; n < 80; n++) begin
         kind = int'($urandom % 4);
         f = nec(8'($urandom), 8'($urandom));
         if ($urandom % 4 == 0) f = f ^ (32'h1 << ($urandom % 32));
         attempt(kind, int'($urandom_range(1, TO)), f, 1'b1, g);
         if (g) tick(1'b0, 8'h0, 8'h0, 1'b1, 1'b0, 1'b1);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
